// File: rtl/q_enc_gen.sv
// Quadrature encoder generator: steps position toward target, emitting A/B/Z with min edge spacing.
// First edge 1 clock after accept, then one per max(period,1) clocks; ena=0 freezes, no backpressure.
module q_enc_gen #(
  parameter int CNT_W = 32,
  parameter int PER_W = 16,
  parameter int CPR   = 4000
) (
  input  logic             clock,
  input  logic             sclr_n,
  input  logic             ena,
  input  logic             dir,
  input  logic [CNT_W-1:0] target,
  input  logic             target_valid,
  input  logic [PER_W-1:0] period,
  input  logic             load,
  input  logic [CNT_W-1:0] load_pos,
  output logic [CNT_W-1:0] position,
  output logic             busy,
  output logic             done,
  output logic             A,
  output logic             B,
  output logic             Z,
  output logic             error
);

  localparam int IDX_W = $clog2(CPR);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(CPR - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_WAIT_LAST} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_pos;
  logic [CNT_W-1:0] r_tgt;
  logic [PER_W-1:0] r_period;
  logic [PER_W-1:0] r_timer;
  logic [IDX_W-1:0] r_idx;
  logic             r_dir;
  logic             r_a;
  logic             r_b;
  logic             r_z;
  logic             r_done;
  logic             r_error;

  logic [CNT_W:0]   w_diff;
  logic             w_down;
  logic [CNT_W-1:0] w_pos_nxt;
  logic [IDX_W-1:0] w_idx_nxt;
  logic             w_at_tgt;
  logic             w_busy;
  logic             w_load_ok;
  logic             w_step;
  logic             w_dir_ld;

  // dir=0: A = p1^p0, B = p1 (A leads on increasing count); dir=1 swaps the pins
  function automatic logic ph_a(input logic [1:0] p, input logic d);
    return d ? p[1] : (p[1] ^ p[0]);
  endfunction

  function automatic logic ph_b(input logic [1:0] p, input logic d);
    return d ? (p[1] ^ p[0]) : p[1];
  endfunction

  // Sign from the widened difference so moves never take the wrap-around shortcut
  assign w_diff    = {r_tgt[CNT_W-1], r_tgt} - {r_pos[CNT_W-1], r_pos};
  assign w_down    = w_diff[CNT_W];
  assign w_pos_nxt = w_down ? (r_pos - CNT_W'(1)) : (r_pos + CNT_W'(1));
  assign w_idx_nxt = w_down ? ((r_idx == '0) ? IDX_MAX : (r_idx - IDX_W'(1)))
                            : ((r_idx == IDX_MAX) ? '0 : (r_idx + IDX_W'(1)));
  assign w_at_tgt  = (r_tgt == r_pos);
  assign w_busy    = (r_state != S_IDLE);
  assign w_load_ok = load && !w_busy;
  assign w_dir_ld  = target_valid ? dir : r_dir;
  assign w_step    = !w_at_tgt && ((r_state == S_IDLE) ||
                                   (r_state == S_WAIT && r_timer == '0));

  always_ff @(posedge clock) begin
    if (!sclr_n) begin
      r_state  <= S_IDLE;
      r_pos    <= '0;
      r_tgt    <= '0;
      r_period <= PER_W'(1);
      r_timer  <= '0;
      r_idx    <= '0;
      r_dir    <= 1'b0;
      r_a      <= 1'b0;
      r_b      <= 1'b0;
      r_z      <= 1'b1;
      r_done   <= 1'b0;
      r_error  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (target_valid) begin
        r_tgt    <= target;
        r_dir    <= dir;
        r_period <= (period == '0) ? PER_W'(1) : period;
      end
      if (load && w_busy) r_error <= 1'b1;

      if (w_load_ok) begin
        r_pos <= load_pos;
        r_idx <= '0;
        r_z   <= 1'b1;
        r_a   <= ph_a(load_pos[1:0], w_dir_ld);
        r_b   <= ph_b(load_pos[1:0], w_dir_ld);
      end else if (ena) begin
        if (w_step) begin
          r_pos   <= w_pos_nxt;
          r_idx   <= w_idx_nxt;
          r_z     <= (w_idx_nxt == '0);
          r_a     <= ph_a(w_pos_nxt[1:0], r_dir);
          r_b     <= ph_b(w_pos_nxt[1:0], r_dir);
          r_timer <= r_period - PER_W'(1);
          r_state <= (w_pos_nxt == r_tgt) ? S_WAIT_LAST : S_WAIT;
        end else begin
          case (r_state)
            S_WAIT: begin
              if (w_at_tgt) r_state <= S_WAIT_LAST;
              if (r_timer != '0) r_timer <= r_timer - PER_W'(1);
            end
            S_WAIT_LAST: begin
              if (!w_at_tgt) begin
                r_state <= S_WAIT;
              end else if (r_timer == '0) begin
                r_state <= S_IDLE;
                r_done  <= 1'b1;
              end else begin
                r_timer <= r_timer - PER_W'(1);
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign position = r_pos;
  assign busy     = w_busy;
  assign done     = r_done;
  assign A        = r_a;
  assign B        = r_b;
  assign Z        = r_z;
  assign error    = r_error;

endmodule
